// File: rtl/pong_msg_pkg.sv
// pong_msg_pkg: message type codes, frame constants and checksum shared by the pong link transmitter and receiver
package pong_msg_pkg;
   typedef enum logic [2:0] {
      MSG_BALL          = 3'd0,
      MSG_MISS          = 3'd1,
      MSG_ARE_YOU_THERE = 3'd2,
      MSG_I_AM_HERE     = 3'd3,
      MSG_NEW_GAME      = 3'd4
   } msg_type_t;
   localparam logic [4:0] SYNC_NIBBLE = 5'b10100;
   localparam int FRAME_BYTES = 5;
   function automatic logic [7:0] frame_checksum(input logic [7:0] h, input logic [7:0] p0,
                                                 input logic [7:0] p1, input logic [7:0] p2);
      return h ^ p0 ^ p1 ^ p2;
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first, CLKS_PER_BIT clocks per bit
// Ports: CLOCK_50/reset (async, active-high); byte_valid/byte_data offer a byte,
// byte_ready is high when idle or on the final stop-bit cycle; txd is the serial line (idle high).
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       txd
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   logic          active;
   logic [BW-1:0] baud;
   logic [3:0]    bit_cnt;
   logic [9:0]    sh;
   logic          bit_end, last, take;
   assign bit_end    = active && baud == BAUD_MAX;
   assign last       = bit_end && bit_cnt == 4'd9;
   // Ready on the final stop-bit cycle lets the next byte start with no idle gap.
   assign byte_ready = !active || last;
   assign take       = byte_valid && byte_ready;
   assign txd        = active ? sh[0] : 1'b1;
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         baud    <= '0;
         bit_cnt <= '0;
         sh      <= '1;
      end else if (take) begin
         active  <= 1'b1;
         baud    <= '0;
         bit_cnt <= '0;
         sh      <= {1'b1, byte_data, 1'b0};
      end else if (last) begin
         active  <= 1'b0;
         baud    <= '0;
         bit_cnt <= '0;
      end else if (bit_end) begin
         baud    <= '0;
         bit_cnt <= bit_cnt + 4'd1;
         sh      <= {1'b1, sh[9:1]};
      end else if (active) begin
         baud    <= baud + BW'(1);
      end
   end
endmodule

// File: rtl/comm_frame_tx.sv
// comm_frame_tx: encodes one game message into a 5-byte frame and sends it 8N1 on UART_TXD
// Ports: CLOCK_50/reset (async, active-high); send_new_message request level with one-hot
// type bits and payload fields; busy spans accept..message_sent; message_sent pulses at frame end.
module comm_frame_tx
   import pong_msg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       send_new_message,
   output logic       message_sent,
   output logic       busy,
   input  logic       ball_message_tx,
   input  logic       miss_message_tx,
   input  logic       new_game_message_tx,
   input  logic       are_you_there_tx,
   input  logic       I_am_here_tx,
   input  logic [8:0] ball_y_tx,
   input  logic [3:0] velocity_x_tx,
   input  logic [3:0] velocity_y_tx,
   input  logic       sign_y_tx,
   input  logic       I_lost_tx,
   input  logic       you_serve_first_tx,
   output logic       UART_TXD
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE, REARM} state_t;
   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);
   state_t                       state, state_n;
   logic [FRAME_BYTES-1:0][7:0]  frame;
   logic [2:0]                   idx;
   msg_type_t                    typ;
   logic [7:0]                   h, p0, p1, p2;
   logic                         any_type, accept, byte_valid, byte_ready, take;
   assign any_type = |{ball_message_tx, miss_message_tx, new_game_message_tx, are_you_there_tx, I_am_here_tx};
   assign typ = ball_message_tx     ? MSG_BALL :
                miss_message_tx     ? MSG_MISS :
                new_game_message_tx ? MSG_NEW_GAME :
                are_you_there_tx    ? MSG_ARE_YOU_THERE : MSG_I_AM_HERE;
   assign h  = {SYNC_NIBBLE, typ};
   assign p0 = typ == MSG_BALL     ? ball_y_tx[7:0] :
               typ == MSG_MISS     ? {7'b0, I_lost_tx} :
               typ == MSG_NEW_GAME ? {7'b0, you_serve_first_tx} : 8'h00;
   assign p1 = typ == MSG_BALL ? {ball_y_tx[8], sign_y_tx, 6'b0} : 8'h00;
   assign p2 = typ == MSG_BALL ? {velocity_x_tx, velocity_y_tx} : 8'h00;
   assign accept     = state == IDLE && send_new_message && any_type;
   assign byte_valid = state == SHIFT && idx != LAST_IDX;
   assign take       = byte_valid && byte_ready;
   assign message_sent = state == DONE;
   assign busy         = state == SHIFT || state == DONE;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = accept ? SHIFT : IDLE;
         // With every byte handed over, byte_ready marks the last stop bit ending.
         SHIFT: state_n = (idx == LAST_IDX && byte_ready) ? DONE : SHIFT;
         DONE:  state_n = REARM;
         REARM: state_n = send_new_message ? REARM : IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         frame <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            frame <= {frame_checksum(h, p0, p1, p2), p2, p1, p0, h};
            idx   <= '0;
         end else if (take) begin
            frame <= frame >> 8;
            idx   <= idx + 3'd1;
         end
      end
   end
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .byte_valid(byte_valid),
      .byte_data (frame[0]),
      .byte_ready(byte_ready),
      .txd       (UART_TXD)
   );
endmodule

// File: tb/tb_comm_frame_tx.sv
// tb_comm_frame_tx: directed and random frames decoded off the line and compared with a reference model
module tb_comm_frame_tx;
   localparam int CPB = 4;
   logic clk = 1'b0, reset = 1'b1, send = 1'b0;
   logic ball = 0, miss = 0, ng = 0, ayt = 0, iah = 0;
   logic [8:0] ball_y = '0;
   logic [3:0] vx = '0, vy = '0;
   logic sign_y = 0, i_lost = 0, serve = 0;
   logic message_sent, busy, txd;
   int checks = 0, errors = 0, cyc = 0, sent_cnt = 0;
   logic [7:0] rx_q[$];
   logic rx_act = 1'b0;
   int rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   comm_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
      .CLOCK_50(clk), .reset(reset), .send_new_message(send), .message_sent(message_sent), .busy(busy),
      .ball_message_tx(ball), .miss_message_tx(miss), .new_game_message_tx(ng),
      .are_you_there_tx(ayt), .I_am_here_tx(iah), .ball_y_tx(ball_y), .velocity_x_tx(vx),
      .velocity_y_tx(vy), .sign_y_tx(sign_y), .I_lost_tx(i_lost), .you_serve_first_tx(serve),
      .UART_TXD(txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (message_sent === 1'b1) sent_cnt++;

   // Line receiver: samples mid-bit, a stop bit that is not high yields a poisoned byte.
   always @(negedge clk) begin
      if (reset) rx_act = 1'b0;
      else if (!rx_act) begin
         if (txd === 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
      end else begin
         rx_cnt++;
         if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2) rx_sh = {txd, rx_sh[7:1]};
         if (rx_cnt == 38) rx_q.push_back(txd === 1'b1 ? rx_sh : 8'hxx);
         if (rx_cnt == 39) rx_act = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame {C,P2,P1,P0,H} built from the message rules with plain arithmetic.
   function automatic logic [39:0] model();
      int t, p0, p1, p2, h, c;
      p0 = 0; p1 = 0; p2 = 0;
      if (ball) t = 0; else if (miss) t = 1; else if (ng) t = 4; else if (ayt) t = 2; else t = 3;
      if (t == 0) begin
         p0 = ball_y % 256;
         p1 = (ball_y / 256) * 128 + sign_y * 64;
         p2 = vx * 16 + vy;
      end
      if (t == 1) p0 = i_lost;
      if (t == 4) p0 = serve;
      h = 160 + t;
      c = h ^ p0 ^ p1 ^ p2;
      return {8'(c), 8'(p2), 8'(p1), 8'(p0), 8'(h)};
   endfunction

   task automatic set_types(input logic [4:0] t);
      {ball, miss, ng, ayt, iah} = t;
   endtask

   task automatic do_frame(input string tag, input logic [39:0] exp, input int hold, input bit scramble);
      int n0, acc, busy_low;
      bit got;
      logic [39:0] e;
      e = exp;
      rx_q.delete();
      n0 = sent_cnt;
      busy_low = 0;
      got = 0;
      @(negedge clk);
      send = 1'b1;
      acc = cyc + 1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (i == 1) chk({tag, " start"}, txd, 1'b0);
         if (scramble && i == 30) begin
            ball_y = 9'($urandom); vx = 4'($urandom); vy = 4'($urandom);
            sign_y = ~sign_y; i_lost = ~i_lost; serve = ~serve;
         end
         if (!busy) busy_low++;
         if (message_sent) got = 1;
      end
      chk({tag, " done"}, got, 1'b1);
      chk({tag, " latency"}, cyc - acc, 201);
      chk({tag, " busy"}, busy_low, 0);
      if (hold == 0) send = 1'b0;
      @(negedge clk);
      chk({tag, " busy_after"}, busy, 1'b0);
      repeat (hold) @(negedge clk);
      send = 1'b0;
      repeat (6) @(negedge clk);
      chk({tag, " nbytes"}, rx_q.size(), 5);
      chk({tag, " npulse"}, sent_cnt - n0, 1);
      for (int i = 0; i < 5; i++) chk($sformatf("%s byte%0d", tag, i), rx_q[i], e[8*i +: 8]);
   endtask

   initial begin
      int n0, bad;
      repeat (3) @(negedge clk);
      chk("rst txd", txd, 1'b1);
      chk("rst sent", message_sent, 1'b0);
      chk("rst busy", busy, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      set_types(5'b10000); ball_y = 9'h15A; vx = 3; vy = 2; sign_y = 1;
      do_frame("ball", 40'h08_32_C0_5A_A0, 0, 0);
      chk("ball model", model(), 40'h08_32_C0_5A_A0);

      set_types(5'b00001);
      do_frame("iah", 40'hA3_00_00_00_A3, 0, 0);

      set_types(5'b01000); i_lost = 1;
      do_frame("miss_hold", 40'hA0_00_00_01_A1, 10, 0);
      repeat (20) @(negedge clk);
      chk("miss no_refire", rx_q.size(), 5);

      set_types(5'b10001); ball_y = 9'h0C7; vx = 9; vy = 4'hE; sign_y = 0;
      do_frame("prio", model(), 0, 1);

      set_types(5'b10000); ball_y = 9'h15A; vx = 3; vy = 2; sign_y = 1;
      n0 = sent_cnt;
      @(negedge clk);
      send = 1'b1;
      repeat (90) @(negedge clk);
      chk("mid low", txd, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid txd", txd, 1'b1);
      chk("mid busy", busy, 1'b0);
      send = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid nopulse", sent_cnt - n0, 0);
      set_types(5'b00100); serve = 1;
      do_frame("newgame", 40'hA5_00_00_01_A4, 0, 0);

      set_types(5'b00000);
      n0 = sent_cnt;
      bad = 0;
      @(negedge clk);
      send = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      send = 1'b0;
      chk("notype line", bad, 0);
      chk("notype pulse", sent_cnt - n0, 0);

      for (int k = 0; k < 8; k++) begin
         set_types(5'($urandom_range(1, 31)));
         ball_y = 9'($urandom); vx = 4'($urandom); vy = 4'($urandom);
         sign_y = 1'($urandom); i_lost = 1'($urandom); serve = 1'($urandom);
         do_frame($sformatf("rnd%0d", k), model(), $urandom_range(0, 3), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/comm_frame_tx.md
# comm_frame_tx

Transmit-side communication stage. Accepts one message request at a time from the game-state FSM: a level `send_new_message` plus a one-hot message type and its payload fields. Encodes the request into a fixed 5-byte frame and serialises it 8N1 onto `UART_TXD` toward the opposing board. Pulses `message_sent` when the last stop bit has completed.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: CLOCK_50 cycles per UART bit (115200 baud). Legal range is ≥ 2.

Ports (CLOCK_50 is the clock; reset is asynchronous, active-high):
- `CLOCK_50` input 1: system clock.
- `reset` input 1: asynchronous reset.
- `send_new_message` input 1: request. Held high until `message_sent` is seen.
- `message_sent` output 1: one-cycle pulse when the frame is complete.
- `busy` output 1: high from accept until `message_sent`, inclusive.
- `ball_message_tx`, `miss_message_tx`, `new_game_message_tx`, `are_you_there_tx`, `I_am_here_tx` input 1 each: message type, expected one-hot.
- `ball_y_tx` input 9: ball row.
- `velocity_x_tx`, `velocity_y_tx` input 4 each: velocity magnitudes.
- `sign_y_tx` input 1: sign of the y velocity.
- `I_lost_tx` input 1: miss payload bit.
- `you_serve_first_tx` input 1: new-game payload bit.
- `UART_TXD` output 1: serial line, idle high.

## Operation

**Frame layout.** Five bytes are sent in this order: H, P0, P1, P2, C. Every byte goes out LSB first as start(0), 8 data bits, stop(1).
- H = {5'b10100, type[2:0]}.
- C = H ^ P0 ^ P1 ^ P2.

**Type codes and payloads:**
- BALL = 0:
  - P0 = `ball_y_tx[7:0]`
  - P1 = {`ball_y_tx[8]`, `sign_y_tx`, 6'b0}
  - P2 = {`velocity_x_tx`, `velocity_y_tx`}
- MISS = 1: P0 = {7'b0, `I_lost_tx`}; P1 = P2 = 0.
- ARE_YOU_THERE = 2: all payload bytes 0.
- I_AM_HERE = 3: all payload bytes 0.
- NEW_GAME = 4: P0 = {7'b0, `you_serve_first_tx`}; P1 = P2 = 0.
- If more than one type bit is high, priority is BALL > MISS > NEW_GAME > ARE_YOU_THERE > I_AM_HERE.
- If `send_new_message` is high with no type bit set, the request is ignored: the block stays in IDLE and emits no pulse.

**FSM states:** IDLE, SHIFT, DONE, REARM.
- IDLE: accept when `send_new_message` = 1 and at least one type bit is set. On accept, latch all five frame bytes (including C) into a byte array, set byte index = 0, go to SHIFT.
- SHIFT: feed bytes 0–4 to the byte serialiser. After byte 4's stop bit finishes, go to DONE.
- DONE: hold for one cycle with `message_sent` = 1, then go to REARM.
- REARM: wait for `send_new_message` = 0, then go to IDLE. This guarantees one frame per request even if the requester holds the level a cycle late.

**Other rules:**
- Input fields are sampled only on the accept cycle. Changes during SHIFT do not affect the frame.
- Reset in the middle of a frame:
  - `UART_TXD` = 1 immediately (asynchronous), state returns to IDLE, and the partial frame is abandoned.
  - The receiver discards the fragment through its checksum and sync-nibble check.

**Reset values:** `UART_TXD` = 1, `message_sent` = 0, `busy` = 0, state = IDLE, byte index = 0, bit counters = 0.

## Timing

- The start bit of H appears on `UART_TXD` on the cycle after the accept edge.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. One byte takes 10·`CLKS_PER_BIT` cycles.
- Bytes are sent back-to-back: the next start bit follows the previous stop bit with zero idle cycles.
- `message_sent` rises exactly 50·`CLKS_PER_BIT` + 1 cycles after the accept edge.
- The earliest next accept is 2 cycles after `message_sent`, provided `send_new_message` dropped on the cycle following the pulse.
- A request arriving during SHIFT, DONE or REARM is not accepted in that state. It is taken once the FSM reaches IDLE, but only if the level is still high then.

## Structure

- Package `pong_msg_pkg`, shared with the receiver, holds:
  - `msg_type_t`, a 3-bit enum of the type codes above.
  - `SYNC_NIBBLE` = 5'b10100.
  - `FRAME_BYTES` = 5.
  - A function `frame_checksum`.
- Sub-module `uart_tx_byte`, parameterised by `CLKS_PER_BIT`:
  - Interface: `byte_valid`, `byte_data[7:0]`, `byte_ready`, `txd`.
  - Contains the baud counter and the 4-bit bit counter.
  - `byte_ready` is high in its idle state and drops the cycle after a byte is taken.
  - It must accept the next byte on the same cycle its stop bit ends, so frame bytes go out back-to-back.

## Test plan

All scenarios run with `CLKS_PER_BIT` = 4.

1. BALL frame: `ball_y_tx` = 9'h15A, `velocity_x_tx` = 3, `velocity_y_tx` = 2, `sign_y_tx` = 1. Line decodes A0, 5A, C0, 32, 08. `message_sent` pulses once, exactly 201 cycles after accept.
2. I_AM_HERE frame. Line decodes A3, 00, 00, 00, A3. `busy` is high throughout and low 1 cycle after the pulse.
3. `send_new_message` held 10 cycles past `message_sent` with MISS and `I_lost_tx` = 1. Exactly one frame is sent (A1, 01, 00, 00, A0). No second frame appears until the level drops and rises again.
4. `ball_message_tx` and `I_am_here_tx` both high. A BALL frame is sent. Payload inputs toggled during SHIFT do not change the transmitted bytes.
5. Reset asserted during byte 2. `UART_TXD` = 1 in the same cycle, with no pulse. After release, a NEW_GAME request with `you_serve_first_tx` = 1 yields A4, 01, 00, 00, A5.
6. Request with no type bit set. `UART_TXD` stays high for 100 cycles and `message_sent` never asserts.
